// File: rtl/bitwise_pkg.sv
// Shared types and constants for the bitwise comparator.
package bitwise_pkg;

    // Default operand width used by the top when no override is given.
    localparam int WIDTH = 2;

    // Widest operand the result struct can carry; match is zero-extended.
    localparam int MAX_WIDTH = 64;

    // Full comparison result for one operand pair.
    typedef struct packed {
        logic                 z;
        logic                 gt;
        logic                 lt;
        logic [MAX_WIDTH-1:0] match;
    } cmp_result_t;

endpackage

// File: rtl/bitwise_compare_core.sv
// Pure combinational compare of two unsigned operands into a cmp_result_t.
module bitwise_compare_core
    import bitwise_pkg::*;
#(
    parameter int WIDTH = bitwise_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output cmp_result_t      res
);

    logic [WIDTH-1:0] bit_eq;

    assign bit_eq = ~(x ^ y);

    // Build the result; bits of match above WIDTH stay zero.
    always_comb begin
        res                   = '0;
        res.match[WIDTH-1:0]  = bit_eq;
        res.z                 = &bit_eq;
        res.gt                = (x > y);
        res.lt                = (x < y);
    end

endmodule

// File: rtl/bitwise_compare.sv
// Registered bitwise equality / magnitude comparator, one cycle latency.
module bitwise_compare
    import bitwise_pkg::*;
#(
    parameter int WIDTH = bitwise_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             z,
    output logic [WIDTH-1:0] match,
    output logic             gt,
    output logic             lt
);

    cmp_result_t res;

    bitwise_compare_core #(.WIDTH(WIDTH)) u_core (
        .x   (x),
        .y   (y),
        .res (res)
    );

    // Upper match bits are always zero padding from the core.
    logic unused_match;
    assign unused_match = ^res.match;

    // Valid flag tracks in_valid one cycle later; reset wins over a new pair.
    always_ff @(posedge clk) begin
        if (rst) out_valid <= 1'b0;
        else     out_valid <= in_valid;
    end

    // Result bank loads only on a valid pair so idle inputs never reach outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            z     <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            match <= '0;
        end else if (in_valid) begin
            z     <= res.z;
            gt    <= res.gt;
            lt    <= res.lt;
            match <= res.match[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_bitwise_compare.sv
// Self-checking bench for bitwise_compare (WIDTH=2) with directed and random pairs.
module tb_bitwise_compare;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] x, y;
    logic         out_valid, z, gt, lt;
    logic [W-1:0] match;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the outputs should show after the last edge.
    logic         m_valid, m_z, m_gt, m_lt;
    logic [W-1:0] m_match;

    bitwise_compare #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .z         (z),
        .match     (match),
        .gt        (gt),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus and advance the reference model.
    task automatic step(input logic r, input logic v, input int a, input int b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        if (v) begin
            x = W'(a);
            y = W'(b);
        end else begin
            x = 'x;
            y = 'x;
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_z = 0; m_gt = 0; m_lt = 0; m_match = '0;
        end else begin
            m_valid = v;
            if (v) begin
                m_z  = (a == b);
                m_gt = (a > b);
                m_lt = (a < b);
                for (int i = 0; i < W; i++)
                    m_match[i] = (((a >> i) & 1) == ((b >> i) & 1));
            end
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if ({out_valid, z, match, gt, lt} !== 6'b0) begin
            failures++;
            $display("FAIL reset: got v=%b z=%b m=%b gt=%b lt=%b want all 0",
                     out_valid, z, match, gt, lt);
        end
    endtask

    task automatic test_gt();
        step(0, 1, 3, 2);
        checks++;
        if ({out_valid, z, match, gt, lt} !== {1'b1, 1'b0, 2'b10, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL gt_3_2: got v=%b z=%b m=%b gt=%b lt=%b want v=1 z=0 m=10 gt=1 lt=0",
                     out_valid, z, match, gt, lt);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 3, 1);
        checks++;
        if ({out_valid, z, match, gt, lt} !== {1'b1, 1'b0, 2'b01, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_3_1: got v=%b z=%b m=%b gt=%b lt=%b want v=1 z=0 m=01 gt=1 lt=0",
                     out_valid, z, match, gt, lt);
        end
        step(0, 1, 2, 1);
        checks++;
        if ({out_valid, z, match, gt, lt} !== {1'b1, 1'b0, 2'b00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_2_1: got v=%b z=%b m=%b gt=%b lt=%b want v=1 z=0 m=00 gt=1 lt=0",
                     out_valid, z, match, gt, lt);
        end
    endtask

    task automatic test_equal();
        step(0, 1, 3, 3);
        checks++;
        if ({out_valid, z, match, gt, lt} !== {1'b1, 1'b1, 2'b11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL eq_3_3: got v=%b z=%b m=%b gt=%b lt=%b want v=1 z=1 m=11 gt=0 lt=0",
                     out_valid, z, match, gt, lt);
        end
        step(0, 1, 1, 1);
        checks++;
        if ({out_valid, z, match, gt, lt} !== {1'b1, 1'b1, 2'b11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL eq_1_1: got v=%b z=%b m=%b gt=%b lt=%b want v=1 z=1 m=11 gt=0 lt=0",
                     out_valid, z, match, gt, lt);
        end
    endtask

    task automatic test_lt();
        step(0, 1, 0, 3);
        checks++;
        if ({out_valid, z, match, gt, lt} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL lt_0_3: got v=%b z=%b m=%b gt=%b lt=%b want v=1 z=0 m=00 gt=0 lt=1",
                     out_valid, z, match, gt, lt);
        end
    endtask

    task automatic test_hold();
        step(0, 1, 3, 3);
        step(0, 0, 0, 0);
        checks++;
        if ({out_valid, z, match, gt, lt} !== {1'b0, 1'b1, 2'b11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL hold: got v=%b z=%b m=%b gt=%b lt=%b want v=0 z=1 m=11 gt=0 lt=0",
                     out_valid, z, match, gt, lt);
        end
        step(0, 0, 0, 0);
        checks++;
        if ({out_valid, z, match} !== {1'b0, 1'b1, 2'b11}) begin
            failures++;
            $display("FAIL hold2: got v=%b z=%b m=%b want v=0 z=1 m=11",
                     out_valid, z, match);
        end
    endtask

    task automatic test_reset_dominates();
        step(0, 1, 3, 1);
        step(1, 1, 2, 2);
        checks++;
        if ({out_valid, z, match, gt, lt} !== 6'b0) begin
            failures++;
            $display("FAIL rst_dom: got v=%b z=%b m=%b gt=%b lt=%b want all 0",
                     out_valid, z, match, gt, lt);
        end
    endtask

    task automatic test_random();
        int a, b, v, r;
        for (int n = 0; n < 300; n++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            r = ($urandom_range(0, 29) == 0) ? 1 : 0;
            step(r[0], v[0], a, b);
            checks++;
            if ({out_valid, z, match, gt, lt} !== {m_valid, m_z, m_match, m_gt, m_lt}) begin
                failures++;
                $display("FAIL rand[%0d]: got v=%b z=%b m=%b gt=%b lt=%b want v=%b z=%b m=%b gt=%b lt=%b",
                         n, out_valid, z, match, gt, lt, m_valid, m_z, m_match, m_gt, m_lt);
            end
            if (out_valid) begin
                checks++;
                if ((32'(z) + 32'(gt) + 32'(lt)) != 1) begin
                    failures++;
                    $display("FAIL onehot[%0d]: got z=%b gt=%b lt=%b want exactly one set",
                             n, z, gt, lt);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
        m_valid = 0; m_z = 0; m_gt = 0; m_lt = 0; m_match = '0;
        test_reset();
        test_gt();
        test_back_to_back();
        test_equal();
        test_lt();
        test_hold();
        test_reset_dominates();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
